// File: rtl/button_conditioner.sv
// Synchronises and debounces raw active-low buttons; emits clean levels plus press/release pulses.
// Define BUTTON_HOLD_REPEAT_EN to add hold-to-repeat press pulses.
module button_conditioner #(
  parameter int NUM_BUTTONS     = 3,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] buttonIn_n,
  output logic [NUM_BUTTONS-1:0] buttonLevel_n,
  output logic [NUM_BUTTONS-1:0] pressPulse,
  output logic [NUM_BUTTONS-1:0] releasePulse
);

  localparam int CntWidth = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(DEBOUNCE_CYCLES - 1);

`ifdef BUTTON_HOLD_REPEAT_EN
  localparam int RptMax   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RptWidth = $clog2(RptMax) + 1;
  localparam logic [RptWidth-1:0] RptFirst = RptWidth'(REPEAT_DELAY - 1);
  localparam logic [RptWidth-1:0] RptNext  = RptWidth'(REPEAT_PERIOD - 1);
`endif

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : gBadParams
    $error("button_conditioner: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  logic [NUM_BUTTONS-1:0] sync1;
  logic [NUM_BUTTONS-1:0] sync2;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= buttonIn_n;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : gChan
    logic                stableQ;
    logic                pressQ;
    logic                releaseQ;
    logic [CntWidth-1:0] cnt;
    logic                accept;
    logic                repeatDue;

    assign accept = (sync2[i] != stableQ) && (cnt == CntLast);

`ifdef BUTTON_HOLD_REPEAT_EN
    // Down-counter reloads on each due repeat; an accepted edge (either way) takes priority.
    logic [RptWidth-1:0] rptCnt;

    assign repeatDue = !stableQ && !accept && (rptCnt == '0);

    always_ff @(posedge clock) begin
      if (reset) begin
        rptCnt <= '0;
      end else if (accept) begin
        rptCnt <= sync2[i] ? '0 : RptFirst;
      end else if (!stableQ) begin
        rptCnt <= (rptCnt == '0) ? RptNext : rptCnt - 1'b1;
      end
    end
`else
    assign repeatDue = 1'b0;
`endif

    always_ff @(posedge clock) begin
      if (reset) begin
        stableQ  <= 1'b1;
        cnt      <= '0;
        pressQ   <= 1'b0;
        releaseQ <= 1'b0;
      end else begin
        pressQ   <= 1'b0;
        releaseQ <= 1'b0;
        if (sync2[i] == stableQ) begin
          cnt <= '0;
        end else if (cnt == CntLast) begin
          stableQ  <= sync2[i];
          cnt      <= '0;
          pressQ   <= ~sync2[i];
          releaseQ <= sync2[i];
        end else begin
          cnt <= cnt + 1'b1;
        end
        if (repeatDue) begin
          pressQ <= 1'b1;
        end
      end
    end

    assign buttonLevel_n[i] = stableQ;
    assign pressPulse[i]    = pressQ;
    assign releasePulse[i]  = releaseQ;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: a window-based reference model predicts every cycle's outputs.
// Honours BUTTON_HOLD_REPEAT_EN the same way the design does.
module tb_button_conditioner;

  localparam int N        = 3;
  localparam int D        = 4;
  localparam int RD       = 10;
  localparam int RP       = 3;
  localparam int MaxEdges = 8192;
`ifdef BUTTON_HOLD_REPEAT_EN
  localparam bit RepeatEn = 1'b1;
`else
  localparam bit RepeatEn = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset;
  logic [N-1:0] buttonIn_n;
  logic [N-1:0] buttonLevel_n;
  logic [N-1:0] pressPulse;
  logic [N-1:0] releasePulse;

  always #5 clock = ~clock;

  button_conditioner #(
    .NUM_BUTTONS    (N),
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .buttonIn_n   (buttonIn_n),
    .buttonLevel_n(buttonLevel_n),
    .pressPulse   (pressPulse),
    .releasePulse (releasePulse)
  );

  typedef struct {
    int           edgeIdx;
    logic [N-1:0] lvl;
    logic [N-1:0] prs;
    logic [N-1:0] rel;
  } exp_t;

  exp_t         expQ[$];
  exp_t         monRec;
  logic [N-1:0] xHist [MaxEdges];
  logic         rHist [MaxEdges];
  int           curEdge = 0;
  int           tests = 0;
  int           failed = 0;
  bit           running = 1'b0;

  logic [N-1:0] mLvl = '1;
  int           pressEdge [N];
  int           pressCnt [N];
  int           releaseCnt [N];
  int           lastPress [N];
  int           lastRelease [N];
  int           runLeft [N];

  // Value the debouncer compares at edge t: the input sampled two edges earlier, forced high by a recent reset.
  function automatic logic sampleAt(int t, int c);
    if (t < 3) return 1'b1;
    if (rHist[t-1] || rHist[t-2]) return 1'b1;
    return xHist[t-2][c];
  endfunction

  // A level flips when the last D synchronised samples all disagree with it; repeats follow the press edge arithmetically.
  task automatic modelEdge(input int e);
    exp_t r;
    r.edgeIdx = e;
    r.prs = '0;
    r.rel = '0;
    for (int c = 0; c < N; c++) begin
      if (rHist[e]) begin
        mLvl[c] = 1'b1;
      end else begin
        bit allDiff;
        int d;
        allDiff = 1'b1;
        for (int j = 0; j < D; j++)
          if (sampleAt(e - j, c) == mLvl[c]) allDiff = 1'b0;
        d = e - pressEdge[c];
        if (allDiff) begin
          mLvl[c] = ~mLvl[c];
          if (mLvl[c] == 1'b0) begin
            r.prs[c] = 1'b1;
            pressEdge[c] = e;
          end else begin
            r.rel[c] = 1'b1;
          end
        end else if (RepeatEn && mLvl[c] == 1'b0 &&
                     (d == RD || (d > RD && (d - RD) % RP == 0))) begin
          r.prs[c] = 1'b1;
        end
      end
    end
    r.lvl = mLvl;
    expQ.push_back(r);
  endtask

  task automatic step(input logic r, input logic [N-1:0] x);
    @(negedge clock);
    reset      = r;
    buttonIn_n = x;
    curEdge++;
    if (curEdge >= MaxEdges) begin
      $display("FAIL edge_budget: got %0d edges, limit %0d", curEdge, MaxEdges);
      $fatal(1, "edge budget exhausted");
    end
    rHist[curEdge] = r;
    xHist[curEdge] = x;
    modelEdge(curEdge);
    running = 1'b1;
  endtask

  task automatic steps(input int n, input logic r, input logic [N-1:0] x);
    for (int i = 0; i < n; i++) step(r, x);
  endtask

  task automatic check(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  always begin
    @(posedge clock);
    #1;
    if (running) begin
      tests++;
      if (expQ.size() == 0) begin
        failed++;
        $display("FAIL scoreboard_empty: got outputs %b/%b/%b, expected a queued prediction",
                 buttonLevel_n, pressPulse, releasePulse);
      end else begin
        monRec = expQ.pop_front();
        if (buttonLevel_n !== monRec.lvl || pressPulse !== monRec.prs || releasePulse !== monRec.rel) begin
          failed++;
          $display("FAIL outputs edge %0d: level got %b exp %b, press got %b exp %b, release got %b exp %b",
                   monRec.edgeIdx, buttonLevel_n, monRec.lvl, pressPulse, monRec.prs,
                   releasePulse, monRec.rel);
        end
        for (int c = 0; c < N; c++) begin
          if (pressPulse[c] === 1'b1) begin
            pressCnt[c]++;
            lastPress[c] = monRec.edgeIdx;
          end
          if (releasePulse[c] === 1'b1) begin
            releaseCnt[c]++;
            lastRelease[c] = monRec.edgeIdx;
          end
        end
      end
    end
  end

  initial begin
    int k;
    int pc;
    int rc;
    int rstLeft;
    logic [N-1:0] cur;

    reset      = 1'b1;
    buttonIn_n = '1;

    // Reset with all released.
    steps(4, 1'b1, 3'b111);

    // Button 0 held low through reset.
    steps(3, 1'b1, 3'b110);
    k = curEdge;
    steps(10, 1'b0, 3'b110);
    check("held_through_reset_press_edge", lastPress[0], k + 6);
    steps(12, 1'b0, 3'b111);

    // Clean press and release on button 1.
    pc = pressCnt[1];
    step(1'b0, 3'b101);
    k = curEdge;
    steps(11, 1'b0, 3'b101);
    check("clean_press_edge", lastPress[1], k + 5);
    check("clean_press_count", pressCnt[1] - pc, 1);
    rc = releaseCnt[1];
    step(1'b0, 3'b111);
    k = curEdge;
    steps(11, 1'b0, 3'b111);
    check("clean_release_edge", lastRelease[1], k + 5);
    check("clean_release_count", releaseCnt[1] - rc, 1);

    // Bounce on button 2 (3-cycle lows), then a steady low.
    pc = pressCnt[2];
    for (int b = 0; b < 2; b++) begin
      steps(3, 1'b0, 3'b011);
      step(1'b0, 3'b111);
    end
    step(1'b0, 3'b011);
    k = curEdge;
    steps(11, 1'b0, 3'b011);
    check("bounce_press_count", pressCnt[2] - pc, 1);
    check("bounce_press_edge", lastPress[2], k + 5);
    steps(12, 1'b0, 3'b111);

    // All three fall together.
    step(1'b0, 3'b000);
    k = curEdge;
    steps(11, 1'b0, 3'b000);
    for (int c = 0; c < N; c++) check("simultaneous_press_edge", lastPress[c], k + 5);
    steps(12, 1'b0, 3'b111);

    // Reset while counts are in progress.
    pc = pressCnt[0] + pressCnt[1] + pressCnt[2];
    steps(4, 1'b0, 3'b000);
    steps(2, 1'b1, 3'b111);
    steps(10, 1'b0, 3'b111);
    check("reset_mid_count_presses", pressCnt[0] + pressCnt[1] + pressCnt[2] - pc, 0);

    // Long hold on button 0: release accepted 25 cycles after the press.
    pc = pressCnt[0];
    rc = releaseCnt[0];
    step(1'b0, 3'b110);
    k = curEdge;
    steps(24, 1'b0, 3'b110);
    steps(15, 1'b0, 3'b111);
    check("hold_press_count", pressCnt[0] - pc, RepeatEn ? 6 : 1);
    check("hold_release_count", releaseCnt[0] - rc, 1);
    check("hold_release_edge", lastRelease[0], k + 30);

    // Randomised runs of mixed lengths with occasional resets.
    cur = '1;
    rstLeft = 0;
    for (int c = 0; c < N; c++) runLeft[c] = 0;
    for (int i = 0; i < 2500; i++) begin
      for (int c = 0; c < N; c++) begin
        if (runLeft[c] == 0) begin
          cur[c]     = 1'($urandom_range(0, 1));
          runLeft[c] = $urandom_range(1, 16);
        end
        runLeft[c]--;
      end
      if (rstLeft == 0 && $urandom_range(0, 199) == 0) rstLeft = $urandom_range(1, 3);
      step(rstLeft > 0, cur);
      if (rstLeft > 0) rstLeft--;
    end
    steps(20, 1'b0, 3'b111);

    @(posedge clock);
    #2;
    running = 1'b0;
    check("scoreboard_drained", expQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Front-end conditioner for the stopwatch's mechanical push buttons (speed, start/pause, reset). It synchronises the raw active-low inputs to `clock`, debounces each one independently, and outputs:

- clean active-low levels, in the same polarity the stopwatch control logic already samples;
- one-cycle press and release pulses for logic running on the fast clock.

It sits between the board pins and the stopwatch control state machine.

## Interface

Parameters:
- `NUM_BUTTONS`, default 3: number of independent button channels.
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable samples required to accept a change (10 ms at 50 MHz); legal range ≥ 1.
- `REPEAT_DELAY`, default 25000000: cycles from accepted press to first auto-repeat pulse; only used with `HOLD_REPEAT_EN`; ≥ 1.
- `REPEAT_PERIOD`, default 5000000: cycles between subsequent auto-repeat pulses; only used with `HOLD_REPEAT_EN`; ≥ 1.

Ports:
- `clock`, input, 1: single system clock; all state updates on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `buttonIn_n`, input, `NUM_BUTTONS`: raw asynchronous buttons; 0 = pressed.
- `buttonLevel_n`, output, `NUM_BUTTONS`: debounced level; 0 = pressed.
- `pressPulse`, output, `NUM_BUTTONS`: one-cycle high on each accepted press (and on each repeat, if enabled).
- `releasePulse`, output, `NUM_BUTTONS`: one-cycle high on each accepted release.

## Operation

Per channel i, all channels fully independent:

- **Synchroniser:** two-flop synchroniser `sync1`, then `sync2`. Only `sync2` is used downstream.
- **Debounce state:** `stable` bit and `cnt` counter, `$clog2(DEBOUNCE_CYCLES)` bits, minimum 1 bit. At each edge:
  - If `sync2 == stable`: `cnt` ← 0.
  - Else, if `cnt == DEBOUNCE_CYCLES-1`: `stable` ← `sync2`, `cnt` ← 0, and fire the matching pulse (press if the new value is 0, release if it is 1).
  - Else: `cnt` ← `cnt+1`.
- **Glitch rejection:** any bounce back to the `stable` value before the count completes clears `cnt`. Glitches shorter than `DEBOUNCE_CYCLES` samples therefore never reach the outputs.
- **Output timing:** `buttonLevel_n[i]` = `stable`. Pulses are registered and asserted in the same cycle `buttonLevel_n` changes.
- **Pulse exclusivity:** `pressPulse[i]` and `releasePulse[i]` are never high together.
- **Simultaneous presses:** presses on several channels in the same cycle produce pulses on all of those channels in the same cycle.
- **Reset values:**
  - `sync1`, `sync2`, `stable`: all 1 (released).
  - `cnt`: 0; repeat counters: 0.
  - `buttonLevel_n`: all 1; `pressPulse` and `releasePulse`: all 0.
  - Reset overrides everything, including mid-count and mid-repeat.
- **Button held through reset:** seen as a fresh press after reset deasserts, and produces a `pressPulse`.

## Timing

- **Acceptance latency:** if raw input changes before edge k and stays steady, the new value is in `sync2` after edge k+1. `stable` and the pulse update at edge k+1+`DEBOUNCE_CYCLES`, i.e. `DEBOUNCE_CYCLES`+2 cycles of latency.
- **Pulse width:** exactly 1 cycle.
- **Press cadence:** at most one accepted press per `DEBOUNCE_CYCLES`+1 cycles per channel.
- **Downstream clocking:** the stopwatch samples `buttonLevel_n` on its divided clock. Holding the button ≥ 1 divided period guarantees it is seen.

## Configuration

Macro: `BUTTON_HOLD_REPEAT_EN`.

- **Defined:** per-channel repeat counter, `$clog2(max(REPEAT_DELAY,REPEAT_PERIOD))+1` bits.
  - Let P be the cycle of the accepted-press pulse.
  - While the button stays accepted-pressed, extra `pressPulse` pulses occur at P+`REPEAT_DELAY`, then every `REPEAT_PERIOD` cycles after that.
  - The counter clears on accepted release and on reset.
  - A release accepted in the same cycle a repeat is due wins: `releasePulse` only, no press pulse.
- **Undefined:** no repeat logic is synthesised. Exactly one `pressPulse` per accepted press.

## Test plan

Use `NUM_BUTTONS`=3, `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=3.

- **Reset:** assert `reset` with all inputs = 1 → `buttonLevel_n`=3'b111, both pulse buses 0. Hold input 0 low through reset and release reset at edge r → `buttonLevel_n[0]`=0 with `pressPulse[0]`=1 at edge r+6.
- **Clean press:** drive `buttonIn_n[1]`=0 before edge k → `buttonLevel_n[1]` falls and `pressPulse[1]`=1 for exactly one cycle after edge k+5. Release the same way → one-cycle `releasePulse[1]` 6 cycles later.
- **Bounce rejection:** pattern 0,0,0,1,0,0,0,1 on input 2 (3-cycle lows) → no output change, no pulses. Then a steady 0 → press accepted 6 cycles after the last transition.
- **Simultaneous events:** all three inputs fall in the same cycle → three pulses in the same cycle. Assert `reset` mid-count (`cnt`=2) → no pulse, outputs at reset values.
- **Auto-repeat (`BUTTON_HOLD_REPEAT_EN` defined):** hold input 0 for 25 cycles past acceptance at P → `pressPulse[0]` at P, P+10, P+13, …, P+22. Release accepted at P+25 → `releasePulse[0]` only, no further press pulses.
- **Macro undefined:** same hold stimulus → exactly one `pressPulse[0]`.
